// File: rtl/cache_pkg.sv
// cache_pkg: shared types for the cache core.
//   lru_cmd_e   - command encoding on the lru_array command port.
//   tag_state_e - control states of tag_lookup.
package cache_pkg;

  typedef enum logic [1:0] {
    LRU_INIT   = 2'b00,
    LRU_TOUCH  = 2'b01,
    LRU_ROTATE = 2'b10,
    LRU_IDLE   = 2'b11
  } lru_cmd_e;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    LOOKUP,
    RESP
  } tag_state_e;

endpackage

// File: rtl/tag_compare.sv
// tag_compare: combinational tag match and priority encoding across the ways of one set.
// Ports:
//   tags_i        - stored tags of every way in the set
//   valid_i       - valid bit of every way
//   tag_i         - tag being looked up
//   hit_o         - some valid way holds tag_i
//   hit_way_o     - lowest matching way
//   any_invalid_o - some way is invalid
//   inv_way_o     - lowest invalid way
module tag_compare #(
  parameter int unsigned ASSOC    = 8,
  parameter int unsigned TAG_SIZE = 20
) (
  input  logic [ASSOC-1:0][TAG_SIZE-1:0] tags_i,
  input  logic [ASSOC-1:0]               valid_i,
  input  logic [TAG_SIZE-1:0]            tag_i,
  output logic                           hit_o,
  output logic [$clog2(ASSOC)-1:0]       hit_way_o,
  output logic                           any_invalid_o,
  output logic [$clog2(ASSOC)-1:0]       inv_way_o
);

  localparam int unsigned WayW = $clog2(ASSOC);

  // Scan from the top down so the lowest-numbered way is the last one written.
  always_comb begin
    hit_o         = 1'b0;
    hit_way_o     = '0;
    any_invalid_o = 1'b0;
    inv_way_o     = '0;
    for (int i = ASSOC - 1; i >= 0; i--) begin
      if (valid_i[i] && (tags_i[i] == tag_i)) begin
        hit_o     = 1'b1;
        hit_way_o = WayW'(i);
      end
      if (!valid_i[i]) begin
        any_invalid_o = 1'b1;
        inv_way_o     = WayW'(i);
      end
    end
  end

endmodule

// File: rtl/tag_lookup.sv
// tag_lookup: tag array and hit/miss stage of the cache core.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   req_valid/req_ready         - lookup request handshake
//   req_tag/req_index/req_write - request tag, set, store flag
//   rsp_valid/rsp_ready         - result handshake
//   rsp_hit/rsp_way             - hit flag, hit way or fill way
//   rsp_evict/rsp_evict_tag     - miss replaced a valid dirty line, and its tag
//   lru_replace/lru_index/lru_assoc - command port to lru_array
//   lru_victim                  - LRU way of lru_index from lru_array
module tag_lookup
  import cache_pkg::*;
#(
  parameter int unsigned ASSOC      = 8,
  parameter int unsigned INDEX_SIZE = 7,
  parameter int unsigned TAG_SIZE   = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [TAG_SIZE-1:0]      req_tag,
  input  logic [INDEX_SIZE-1:0]    req_index,
  input  logic                     req_write,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_hit,
  output logic [$clog2(ASSOC)-1:0] rsp_way,
  output logic                     rsp_evict,
  output logic [TAG_SIZE-1:0]      rsp_evict_tag,
  output logic [1:0]               lru_replace,
  output logic [INDEX_SIZE-1:0]    lru_index,
  output logic [$clog2(ASSOC)-1:0] lru_assoc,
  input  logic [$clog2(ASSOC)-1:0] lru_victim
);

  localparam int unsigned Sets = 2 ** INDEX_SIZE;
  localparam int unsigned WayW = $clog2(ASSOC);
  localparam logic [INDEX_SIZE-1:0] LastSet = '1;

  tag_state_e state_q, state_d;
  logic [INDEX_SIZE-1:0] init_cnt_q, init_cnt_d;

  logic [TAG_SIZE-1:0]   cap_tag_q, cap_tag_d;
  logic [INDEX_SIZE-1:0] cap_index_q, cap_index_d;
  logic                  cap_write_q, cap_write_d;

  logic                rsp_hit_q, rsp_hit_d;
  logic [WayW-1:0]     rsp_way_q, rsp_way_d;
  logic                rsp_evict_q, rsp_evict_d;
  logic [TAG_SIZE-1:0] rsp_evict_tag_q, rsp_evict_tag_d;

  // Storage: tags are never reset; valid/dirty are cleared by the INIT walk.
  logic [ASSOC-1:0][TAG_SIZE-1:0] tag_q   [Sets];
  logic [ASSOC-1:0]               valid_q [Sets];
  logic [ASSOC-1:0]               dirty_q [Sets];

  logic [ASSOC-1:0][TAG_SIZE-1:0] set_tags;
  logic [ASSOC-1:0]               set_valid;
  logic [ASSOC-1:0]               set_dirty;

  logic            cmp_hit;
  logic [WayW-1:0] cmp_hit_way;
  logic            cmp_any_inv;
  logic [WayW-1:0] cmp_inv_way;

  logic            lk_evict;
  logic [WayW-1:0] lk_way;
  lru_cmd_e        lru_cmd;

  assign set_tags  = tag_q[cap_index_q];
  assign set_valid = valid_q[cap_index_q];
  assign set_dirty = dirty_q[cap_index_q];

  tag_compare #(
    .ASSOC    (ASSOC),
    .TAG_SIZE (TAG_SIZE)
  ) u_tag_compare (
    .tags_i        (set_tags),
    .valid_i       (set_valid),
    .tag_i         (cap_tag_q),
    .hit_o         (cmp_hit),
    .hit_way_o     (cmp_hit_way),
    .any_invalid_o (cmp_any_inv),
    .inv_way_o     (cmp_inv_way)
  );

  // Victim choice: hit way, else first invalid way, else LRU way from lru_array.
  always_comb begin
    if (cmp_hit) begin
      lk_way = cmp_hit_way;
    end else if (cmp_any_inv) begin
      lk_way = cmp_inv_way;
    end else begin
      lk_way = lru_victim;
    end
    lk_evict = !cmp_hit && set_valid[lk_way] && set_dirty[lk_way];
  end

  always_comb begin
    state_d         = state_q;
    init_cnt_d      = init_cnt_q;
    cap_tag_d       = cap_tag_q;
    cap_index_d     = cap_index_q;
    cap_write_d     = cap_write_q;
    rsp_hit_d       = rsp_hit_q;
    rsp_way_d       = rsp_way_q;
    rsp_evict_d     = rsp_evict_q;
    rsp_evict_tag_d = rsp_evict_tag_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    lru_cmd         = LRU_IDLE;
    lru_index       = cap_index_q;
    lru_assoc       = '0;

    unique case (state_q)
      INIT: begin
        lru_cmd    = LRU_INIT;
        lru_index  = init_cnt_q;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == LastSet) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cap_tag_d   = req_tag;
          cap_index_d = req_index;
          cap_write_d = req_write;
          state_d     = LOOKUP;
        end
      end
      LOOKUP: begin
        lru_cmd         = LRU_TOUCH;
        lru_assoc       = lk_way;
        rsp_hit_d       = cmp_hit;
        rsp_way_d       = lk_way;
        rsp_evict_d     = lk_evict;
        rsp_evict_tag_d = lk_evict ? set_tags[lk_way] : '0;
        state_d         = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            cap_tag_d   = req_tag;
            cap_index_d = req_index;
            cap_write_d = req_write;
            state_d     = LOOKUP;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign lru_replace   = lru_cmd;
  assign rsp_hit       = rsp_hit_q;
  assign rsp_way       = rsp_way_q;
  assign rsp_evict     = rsp_evict_q;
  assign rsp_evict_tag = rsp_evict_tag_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= INIT;
      init_cnt_q      <= '0;
      cap_tag_q       <= '0;
      cap_index_q     <= '0;
      cap_write_q     <= 1'b0;
      rsp_hit_q       <= 1'b0;
      rsp_way_q       <= '0;
      rsp_evict_q     <= 1'b0;
      rsp_evict_tag_q <= '0;
    end else begin
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      cap_tag_q       <= cap_tag_d;
      cap_index_q     <= cap_index_d;
      cap_write_q     <= cap_write_d;
      rsp_hit_q       <= rsp_hit_d;
      rsp_way_q       <= rsp_way_d;
      rsp_evict_q     <= rsp_evict_d;
      rsp_evict_tag_q <= rsp_evict_tag_d;
    end
  end

  // Array updates are keyed off state_q, which reset forces to INIT, so an
  // in-flight lookup never commits once rst is seen.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      valid_q[init_cnt_q] <= '0;
      dirty_q[init_cnt_q] <= '0;
    end else if (state_q == LOOKUP) begin
      if (cmp_hit) begin
        if (cap_write_q) begin
          dirty_q[cap_index_q][lk_way] <= 1'b1;
        end
      end else begin
        tag_q[cap_index_q][lk_way]   <= cap_tag_q;
        valid_q[cap_index_q][lk_way] <= 1'b1;
        dirty_q[cap_index_q][lk_way] <= cap_write_q;
      end
    end
  end

endmodule

// File: tb/tb_tag_lookup.sv
module tb_tag_lookup;

  localparam int unsigned ASSOC      = 8;
  localparam int unsigned INDEX_SIZE = 7;
  localparam int unsigned TAG_SIZE   = 20;
  localparam int unsigned SETS       = 128;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  req_valid = 1'b0;
  logic                  req_ready;
  logic [TAG_SIZE-1:0]   req_tag = '0;
  logic [INDEX_SIZE-1:0] req_index = '0;
  logic                  req_write = 1'b0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b1;
  logic                  rsp_hit;
  logic [2:0]            rsp_way;
  logic                  rsp_evict;
  logic [TAG_SIZE-1:0]   rsp_evict_tag;
  logic [1:0]            lru_replace;
  logic [INDEX_SIZE-1:0] lru_index;
  logic [2:0]            lru_assoc;
  logic [2:0]            lru_victim = '0;

  tag_lookup #(
    .ASSOC      (ASSOC),
    .INDEX_SIZE (INDEX_SIZE),
    .TAG_SIZE   (TAG_SIZE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_tag       (req_tag),
    .req_index     (req_index),
    .req_write     (req_write),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_hit       (rsp_hit),
    .rsp_way       (rsp_way),
    .rsp_evict     (rsp_evict),
    .rsp_evict_tag (rsp_evict_tag),
    .lru_replace   (lru_replace),
    .lru_index     (lru_index),
    .lru_assoc     (lru_assoc),
    .lru_victim    (lru_victim)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level cache model.
  bit [TAG_SIZE-1:0]   m_tag   [SETS][ASSOC];
  bit                  m_valid [SETS][ASSOC];
  bit                  m_dirty [SETS][ASSOC];
  int                  init_left = SETS;
  bit                  in_lookup = 0;
  bit                  rsp_pend  = 0;
  bit [TAG_SIZE-1:0]   lk_tag;
  bit [INDEX_SIZE-1:0] lk_index;
  bit                  lk_write;
  bit                  e_hit;
  int                  e_way;
  bit                  e_evict;
  bit [TAG_SIZE-1:0]   e_evtag;
  bit                  exp_ready;
  bit                  accept;
  bit                  done;
  int                  hw;
  int                  fw;

  // Inputs change only at posedge+1, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_hit", rsp_hit, 0);
      chk("rst_rsp_way", rsp_way, 0);
      chk("rst_rsp_evict", rsp_evict, 0);
      chk("rst_rsp_evict_tag", rsp_evict_tag, 0);
      chk("rst_lru_replace", lru_replace, 2'b00);
      chk("rst_lru_index", lru_index, 0);
      chk("rst_lru_assoc", lru_assoc, 0);
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < ASSOC; w++) begin
          m_valid[s][w] = 0;
          m_dirty[s][w] = 0;
        end
      end
      init_left = SETS;
      in_lookup = 0;
      rsp_pend  = 0;
    end else if (init_left > 0) begin
      chk("init_lru_replace", lru_replace, 2'b00);
      chk("init_req_ready", req_ready, 0);
      chk("init_rsp_valid", rsp_valid, 0);
      init_left--;
    end else begin
      exp_ready = !in_lookup && (!rsp_pend || rsp_ready);
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, rsp_pend);
      if (in_lookup) begin
        hw = -1;
        for (int w = 0; w < ASSOC; w++) begin
          if (hw < 0 && m_valid[lk_index][w] && m_tag[lk_index][w] == lk_tag) hw = w;
        end
        if (hw >= 0) begin
          e_hit   = 1;
          e_way   = hw;
          e_evict = 0;
          if (lk_write) m_dirty[lk_index][hw] = 1;
        end else begin
          fw = -1;
          for (int w = 0; w < ASSOC; w++) begin
            if (fw < 0 && !m_valid[lk_index][w]) fw = w;
          end
          if (fw < 0) fw = int'(lru_victim);
          e_hit   = 0;
          e_way   = fw;
          e_evict = m_valid[lk_index][fw] && m_dirty[lk_index][fw];
          e_evtag = m_tag[lk_index][fw];
          m_tag[lk_index][fw]   = lk_tag;
          m_valid[lk_index][fw] = 1;
          m_dirty[lk_index][fw] = lk_write;
        end
        chk("lookup_lru_replace", lru_replace, 2'b01);
        chk("lookup_lru_index", lru_index, lk_index);
        chk("lookup_lru_assoc", lru_assoc, e_way);
      end else begin
        chk("idle_lru_replace", lru_replace, 2'b11);
      end
      if (rsp_pend) begin
        chk("rsp_hit", rsp_hit, e_hit);
        chk("rsp_way", rsp_way, e_way);
        chk("rsp_evict", rsp_evict, e_evict);
        if (e_evict) chk("rsp_evict_tag", rsp_evict_tag, e_evtag);
      end
      accept = req_valid && exp_ready;
      done   = rsp_pend && rsp_ready;
      if (in_lookup) rsp_pend = 1;
      else if (done) rsp_pend = 0;
      in_lookup = accept;
      if (accept) begin
        lk_tag   = req_tag;
        lk_index = req_index;
        lk_write = req_write;
      end
    end
  end

  // Releases reset and counts the cycles before req_ready first rises.
  task automatic wait_init(input string name);
    int n;
    n = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    chk({name, "_init_len"}, n, 128);
    @(posedge clk);
    #1;
  endtask

  // One request with rsp_ready high; literal expectations for the result.
  task automatic do_req(input logic [TAG_SIZE-1:0] tag, input logic [INDEX_SIZE-1:0] idx,
                        input bit wr, input logic [2:0] victim, input bit x_hit,
                        input int x_way, input bit x_evict, input logic [TAG_SIZE-1:0] x_evtag,
                        input string name);
    bit ok;
    ok         = 0;
    lru_victim = victim;
    req_tag    = tag;
    req_index  = idx;
    req_write  = wr;
    req_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1;
        break;
      end
    end
    chk({name, "_accept"}, ok, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk({name, "_touch"}, lru_replace, 2'b01);
    chk({name, "_touch_way"}, lru_assoc, x_way);
    chk({name, "_early_rsp"}, rsp_valid, 0);
    @(negedge clk);
    chk({name, "_rsp_valid"}, rsp_valid, 1);
    chk({name, "_hit"}, rsp_hit, x_hit);
    chk({name, "_way"}, rsp_way, x_way);
    chk({name, "_evict"}, rsp_evict, x_evict);
    if (x_evict) chk({name, "_evict_tag"}, rsp_evict_tag, x_evtag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    wait_init("boot");

    do_req(20'h123, 7'd5, 0, 3'd0, 0, 0, 0, 20'h0, "cold_miss");
    do_req(20'h123, 7'd5, 0, 3'd0, 1, 0, 0, 20'h0, "rehit");
    for (int w = 1; w < ASSOC; w++) begin
      do_req(TAG_SIZE'(32'h200 + w), 7'd5, 1, 3'd0, 0, w, 0, 20'h0, "fill");
    end
    do_req(20'h123, 7'd5, 1, 3'd0, 1, 0, 0, 20'h0, "write_hit");
    do_req(20'h999, 7'd5, 0, 3'd3, 0, 3, 1, 20'h203, "evict_lru");
    do_req(20'h205, 7'd5, 0, 3'd0, 1, 5, 0, 20'h0, "hit_way5");
    do_req(20'haaa, 7'd5, 0, 3'd0, 0, 0, 1, 20'h123, "evict_wrhit");
    do_req(20'hbbb, 7'd5, 0, 3'd3, 0, 3, 0, 20'h0, "evict_clean");

    // Back-pressure: result held for 5 cycles, then a new request rides the release edge.
    lru_victim = 3'd0;
    req_tag    = 20'h55;
    req_index  = 7'd9;
    req_write  = 1'b0;
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    @(negedge clk);
    chk("stall_accept", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_hit", rsp_hit, 0);
      chk("stall_way", rsp_way, 0);
      chk("stall_req_ready", req_ready, 0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_write = 1'b1;
    @(negedge clk);
    chk("release_accept", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("release_lookup_no_rsp", rsp_valid, 0);
    @(negedge clk);
    chk("release_rsp_valid", rsp_valid, 1);
    chk("release_hit", rsp_hit, 1);
    chk("release_way", rsp_way, 0);
    @(posedge clk);
    #1;

    // Reset lands while the request is in LOOKUP.
    req_tag   = 20'h202;
    req_index = 7'd5;
    req_write = 1'b0;
    req_valid = 1'b1;
    @(negedge clk);
    chk("rstmid_accept", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_rsp", rsp_valid, 0);
    end
    wait_init("reinit");
    do_req(20'h202, 7'd5, 0, 3'd0, 0, 0, 0, 20'h0, "post_reset_miss");

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
